// File: rtl/multu_seq_if.sv
// Bundle between the control unit / writeback mux and the MULTU sequencer.
// Handshake: a request is taken on a rising edge where mult_enable=1 and busy=0; while busy=1, a pending mult_enable or sf2reg raises stall and must be held until stall drops.
interface multu_seq_if #(
  parameter int WIDTH = 32
);
  logic             mult_enable;
  logic [WIDTH-1:0] rs_data;
  logic [WIDTH-1:0] rt_data;
  logic             sf2reg;
  logic             sfmux_high;
  logic [WIDTH-1:0] sf_out;
  logic             busy;
  logic             stall;
  logic             done;
  logic             state_dbg;

  modport master (
    output mult_enable, rs_data, rt_data, sf2reg, sfmux_high,
    input  sf_out, busy, stall, done, state_dbg
  );

  modport slave (
    input  mult_enable, rs_data, rt_data, sf2reg, sfmux_high,
    output sf_out, busy, stall, done, state_dbg
  );
endinterface

// File: rtl/multu_seq.sv
// Radix-2 shift-add unsigned multiplier, one iteration per cycle.
// The product is committed to HI/LO on the final iteration edge only.
module multu_seq #(
  parameter int WIDTH = 32
) (
  input logic        clk,
  input logic        rst,
  multu_seq_if.slave bus
);
  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  localparam logic [WIDTH-1:0] LAST = WIDTH'(WIDTH - 1);

  state_t             state;
  logic [WIDTH-1:0]   cnt;
  logic [WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]   hi;
  logic [WIDTH-1:0]   lo;
  logic [2*WIDTH:0]   p;
  logic               done_q;

  logic [WIDTH:0]     upper;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH:0]   p_next;

  // Upper part is WIDTH+1 bits wide so the add carry survives the shift.
  always_comb begin
    upper  = p[2*WIDTH:WIDTH];
    sum    = p[0] ? (upper + {1'b0, mcand}) : upper;
    p_next = {sum, p[WIDTH-1:0]} >> 1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      p      <= '0;
      mcand  <= '0;
      hi     <= '0;
      lo     <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.mult_enable) begin
            p     <= {1'b0, {WIDTH{1'b0}}, bus.rt_data};
            mcand <= bus.rs_data;
            cnt   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          p   <= p_next;
          cnt <= cnt + WIDTH'(1);
          if (cnt == LAST) begin
            hi     <= p_next[2*WIDTH-1:WIDTH];
            lo     <= p_next[WIDTH-1:0];
            done_q <= 1'b1;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy      = (state == RUN);
  assign bus.stall     = bus.busy & (bus.sf2reg | bus.mult_enable);
  assign bus.done      = done_q;
  assign bus.sf_out    = bus.sfmux_high ? hi : lo;
  assign bus.state_dbg = state;
endmodule

// File: tb/tb_multu_seq.sv
// Directed bench for multu_seq: hand-computed products, stall/busy windows,
// back-to-back MULTU, mid-run reset and idle reads.
module tb_multu_seq;
  localparam int W = 32;

  logic clk;
  logic rst;
  int   assert_cnt;
  int   fail_cnt;

  multu_seq_if #(.WIDTH(W)) bus ();

  multu_seq #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    assert_cnt++;
    if (got !== exp) begin
      fail_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // drivers: inputs change and outputs are sampled at the falling edge
  task automatic start_multu(input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    bus.mult_enable = 1'b1;
    bus.rs_data     = a;
    bus.rt_data     = b;
    @(negedge clk);
    bus.mult_enable = 1'b0;
  endtask

  // Call in the cycle after the request edge; returns in the done cycle.
  task automatic count_busy(output int n);
    n = 0;
    while (bus.busy && n < 200) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic read_hilo(input string tag, input logic [W-1:0] exp_hi, input logic [W-1:0] exp_lo);
    bus.sfmux_high = 1'b1;
    #1;
    check({tag, "_hi"}, 64'(bus.sf_out), 64'(exp_hi));
    bus.sfmux_high = 1'b0;
    #1;
    check({tag, "_lo"}, 64'(bus.sf_out), 64'(exp_lo));
  endtask

  task automatic finish_multu(input string tag, input logic [W-1:0] exp_hi, input logic [W-1:0] exp_lo);
    int n;
    check({tag, "_busy_start"}, 64'(bus.busy), 64'd1);
    count_busy(n);
    check({tag, "_busy_cycles"}, 64'(n), 64'd32);
    check({tag, "_done"}, 64'(bus.done), 64'd1);
    read_hilo(tag, exp_hi, exp_lo);
    @(negedge clk);
    check({tag, "_done_drop"}, 64'(bus.done), 64'd0);
  endtask

  initial begin : stim
    int n;
    int done_seen;
    assert_cnt      = 0;
    fail_cnt        = 0;
    rst             = 1'b1;
    bus.mult_enable = 1'b0;
    bus.rs_data     = '0;
    bus.rt_data     = '0;
    bus.sf2reg      = 1'b0;
    bus.sfmux_high  = 1'b0;

    repeat (2) @(negedge clk);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_done", 64'(bus.done), 64'd0);
    check("rst_stall", 64'(bus.stall), 64'd0);
    read_hilo("rst", 32'h0, 32'h0);
    rst = 1'b0;

    // 3 x 5
    start_multu(32'd3, 32'd5);
    finish_multu("m3x5", 32'h0000_0000, 32'h0000_000F);

    // all-ones: carry must be kept in the upper part
    start_multu(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    finish_multu("mff", 32'hFFFF_FFFE, 32'h0000_0001);

    // MFHI issued the cycle after the request edge
    start_multu(32'h0001_0000, 32'h0001_0000);
    bus.sf2reg     = 1'b1;
    bus.sfmux_high = 1'b1;
    #1;
    check("mfhi_old_hi", 64'(bus.sf_out), 64'hFFFF_FFFE);
    n = 0;
    while (bus.stall && n < 200) begin
      n++;
      @(negedge clk);
      #1;
    end
    check("mfhi_stall_cycles", 64'(n), 64'd32);
    check("mfhi_done", 64'(bus.done), 64'd1);
    check("mfhi_hi", 64'(bus.sf_out), 64'h0000_0001);
    bus.sfmux_high = 1'b0;
    #1;
    check("mfhi_lo", 64'(bus.sf_out), 64'h0000_0000);
    bus.sf2reg = 1'b0;

    // second MULTU held behind the first
    start_multu(32'd6, 32'd7);
    bus.mult_enable = 1'b1;
    bus.rs_data     = 32'd7;
    bus.rt_data     = 32'd9;
    #1;
    n = 0;
    while (bus.stall && n < 200) begin
      n++;
      @(negedge clk);
      #1;
    end
    check("b2b_stall_cycles", 64'(n), 64'd32);
    check("b2b_first_done", 64'(bus.done), 64'd1);
    read_hilo("b2b_first", 32'h0, 32'd42);
    @(negedge clk);
    bus.mult_enable = 1'b0;
    finish_multu("b2b_second", 32'h0, 32'h0000_003F);

    // reset in the middle of a run
    start_multu(32'h0000_FFFF, 32'h0000_FFFF);
    repeat (9) @(negedge clk);
    check("abort_busy_pre", 64'(bus.busy), 64'd1);
    rst = 1'b1;
    #1;
    check("abort_busy", 64'(bus.busy), 64'd0);
    read_hilo("abort", 32'h0, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    done_seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done) done_seen++;
    end
    check("abort_no_done", 64'(done_seen), 64'd0);
    start_multu(32'd2, 32'd4);
    finish_multu("m2x4", 32'h0, 32'd8);

    // idle MFLO, then request together with read
    bus.sf2reg     = 1'b1;
    bus.sfmux_high = 1'b0;
    #1;
    check("idle_read_stall", 64'(bus.stall), 64'd0);
    check("idle_read_lo", 64'(bus.sf_out), 64'd8);
    @(negedge clk);
    bus.mult_enable = 1'b1;
    bus.rs_data     = 32'd0;
    bus.rt_data     = 32'hDEAD_BEEF;
    #1;
    check("both_idle_stall", 64'(bus.stall), 64'd0);
    check("both_idle_lo", 64'(bus.sf_out), 64'd8);
    @(negedge clk);
    bus.mult_enable = 1'b0;
    bus.sf2reg      = 1'b0;
    finish_multu("m0xdead", 32'h0, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
    $finish;
  end
endmodule

// File: doc/multu_seq.md
# multu_seq

Iterative sequencer for the unsigned multiply unit behind MULTU/MFHI/MFLO. It accepts a MULTU start from the control unit, runs a radix-2 shift-add multiply over WIDTH cycles, and commits the product into the HI/LO registers. It stalls the pipeline when an MFHI/MFLO read or a second MULTU arrives while a multiply is in flight. It sits between the control unit (mult_enable, sfmux_high, sf2reg) and the writeback mux that consumes sf_out.

## Interface

- WIDTH, 32, operand width; product is 2*WIDTH bits, split into HI and LO.

- clk  in  1  clock, rising edge.
- rst  in  1  reset; asynchronous, active-high.
- mult_enable  in  1  MULTU request; operands valid in the same cycle.
- rs_data  in  WIDTH  multiplicand.
- rt_data  in  WIDTH  multiplier.
- sf2reg  in  1  MFHI/MFLO read request.
- sfmux_high  in  1  read select: 1 = HI, 0 = LO.
- sf_out  out  WIDTH  selected HI or LO; combinational from the registers.
- busy  out  1  multiply in flight.
- stall  out  1  freeze the pipeline front end; combinational.
- done  out  1  one-cycle pulse when HI/LO update.

## Operation

- States: IDLE and RUN. There is a WIDTH-bit iteration counter cnt and a (2*WIDTH+1)-bit product register P.
- IDLE with mult_enable = 1 at an edge:
  - P <= {1'b0, WIDTH'b0, rt_data}; mcand <= rs_data; cnt <= 0; state <= RUN.
- Each RUN edge:
  - If P[0] = 1, the upper part is sum = P[2W:W] + mcand, computed WIDTH+1 bits wide so the carry is kept. Otherwise sum = P[2W:W].
  - P <= {sum, P[W-1:0]} >> 1. Then cnt <= cnt + 1.
- RUN edge with cnt = WIDTH-1:
  - The final iteration result goes directly to the registers: HI <= P_next[2W-1:W], LO <= P_next[W-1:0].
  - state <= IDLE; done <= 1 for the following cycle only.
- HI/LO hold their previous values throughout RUN. They change only on the final iteration edge or on reset.
- busy = (state == RUN).
- stall = busy & (sf2reg | mult_enable).
  - A held request is accepted in the first cycle that busy = 0.
  - MULTU stalled behind a MULTU starts on the first edge after the earlier one completes.
- sf_out = sfmux_high ? HI : LO at all times, independent of state.
- mult_enable and sf2reg together in IDLE: the multiply starts, there is no stall, and sf_out returns the pre-multiply HI/LO.
- mult_enable is ignored as a start while in RUN. It only contributes to stall.
- Arithmetic is unsigned only. No overflow is possible; the product always fits in 2*WIDTH bits.

## Timing

- Reset values (asynchronous, immediate): state = IDLE, cnt = 0, P = 0, mcand = 0, HI = 0, LO = 0, busy = 0, done = 0. stall = 0 because busy = 0. sf_out = 0.
- Edge E0 accepts the request. Edges E1..EW perform the iterations; HI/LO are written at EW.
  - busy is high for exactly WIDTH cycles: the cycles following E0 through the cycle ending at EW.
  - done is high in the cycle after EW. New HI/LO are visible on sf_out in that same cycle.
- Start-to-result latency is WIDTH+1 edges after the request edge.
- An MFHI presented in the cycle after E0 stalls for WIDTH cycles and reads the new value in the cycle after EW.
- Reset asserted mid-RUN aborts the multiply: HI/LO are cleared to 0, done does not pulse, and the block returns to IDLE.
- Minimum back-to-back throughput is one MULTU per WIDTH+1 cycles.

## Test plan

- Reset, then rs = 3, rt = 5 with mult_enable for 1 cycle:
  - busy is high for 32 cycles, then done pulses.
  - LO = 0x0000000F, HI = 0x00000000.
- rs = rt = 0xFFFFFFFF:
  - HI = 0xFFFFFFFE, LO = 0x00000001. This checks that the carry is kept in the upper part.
- MULTU 0x00010000 × 0x00010000, then sf2reg = 1, sfmux_high = 1 in the next cycle:
  - stall is high for exactly 32 cycles.
  - Then sf_out = 0x00000001, and LO reads 0x00000000.
- Second MULTU (7 × 9) held on mult_enable during the first multiply:
  - stall is high until the first completes.
  - The second starts one cycle after the first done, and the final LO = 0x0000003F.
- Reset pulse at cycle 10 of a multiply:
  - busy = 0, HI = LO = 0, and done never pulses.
  - A subsequent MULTU 2 × 4 gives LO = 8.
- Operand 0 (0 × 0xDEADBEEF) and MFLO in IDLE with no multiply pending:
  - The multiply gives HI = LO = 0.
  - The idle read has no stall and returns the current LO immediately.
